ccg_bist_stim_misr: RTL
=======================

# ccg_bist_stim_misr

Built-in self-test harness for the generated combinational benchmarks in the GCN_AIG dataset (x0..x4 inputs, f1..f14 outputs). The block is the driving and sampling end of a benchmark's interface. It applies every input pattern to the benchmark exhaustively, and it compacts the benchmark's responses into a multiple-input signature register (MISR). The resulting signature is compared against the signature computed offline from the ABC netlist. It sits between the dataset regression controller and one instantiated benchmark netlist.

## Interface
Parameters:
- N_IN, 5, benchmark input count. Patterns 0..2^N_IN−1 are applied.
- N_OUT, 14, benchmark output count. Must be ≤ SIG_W.
- SIG_W, 16, MISR width.
- POLY, 16'h1021, MISR feedback polynomial. Bit SIG_W is implicit.
- GOLDEN, 16'h0000, expected signature. Used only with CCG_BIST_CMP_EN.

Ports:
- clk  in  1  single clock. Rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request. Sampled only in IDLE.
- x  out  N_IN  pattern to benchmark inputs x0..x(N_IN−1). Registered.
- f  in  N_OUT  benchmark responses f1..fN_OUT, with f[0]=f1. Purely combinational from x.
- busy  out  1  high while patterns are applied.
- done  out  1  one-cycle pulse when the signature is final.
- signature  out  SIG_W  MISR contents. Held after done.
- pass  out  1  signature==GOLDEN, registered with done. Tied 0 without CCG_BIST_CMP_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - x=0, busy=0, done=0, and signature holds its last value.
  - start=1 → RUN. On that edge: x←0, MISR←0, pattern counter←0.
- RUN, one cycle per pattern:
  - MISR update: sig ← (sig<<1) ^ (sig[SIG_W−1] ? POLY : 0) ^ zero_extend(f).
  - The counter increments and x follows the counter.
  - The update for the final pattern (x=2^N_IN−1) transitions to DONE.
  - x then returns to 0.
- DONE:
  - done=1 for exactly one cycle and busy=0.
  - The state then returns to IDLE unconditionally.
  - start is ignored in DONE.
- Counter width is N_IN+1 so the terminal pattern can be detected. x never wraps within a run.
- start in RUN or DONE is ignored. It is not queued.
- Asynchronous reset at any time, including mid-run:
  - state=IDLE, x=0, busy=0, done=0, signature=0, pass=0.
  - The partial signature is discarded.

## Timing
- Edge E0: start sampled high in IDLE. From after E0: busy=1, x=0.
- Edges E1..E(2^N_IN): absorb f for x=0..2^N_IN−1. The default configuration uses 32 absorb edges.
- After E(2^N_IN): done=1 and busy=0, with signature and pass valid.
- After E(2^N_IN+1): back in IDLE. A new start is accepted on that edge or later.
- Latency from start edge to done-high: 2^N_IN cycles. Minimum start-to-start spacing: 2^N_IN+2 edges.
- f must settle within one clock period of x changing. No input registering is applied to f.

## Configuration
- CCG_BIST_CMP_EN defined:
  - pass is registered on the edge entering DONE as (final signature == GOLDEN).
  - pass holds until the next start or reset. It clears to 0 on start.
- CCG_BIST_CMP_EN undefined: no comparator is built, GOLDEN is unused, and pass is constant 0.

## Test plan
- Stub DUT with f=0 constant, start pulse:
  - x steps 0..31 on consecutive cycles and busy is high for 32 cycles.
  - done pulses on the 33rd cycle after the start edge.
  - signature=16'h0000.
- Stub f=14'h0001 only when x=31, else 0 → signature=16'h0001.
- Stub f=14'h0001 only when x=30 → signature=16'h0002.
- Stub f=14'h0001 only when x=0 → signature=16'h1B98. This checks 31 shifts including feedback.
- Reset and start interactions:
  - Assert rst_n=0 at x=17 → all outputs 0 immediately.
  - After release, start runs a full fresh 32-pattern pass.
  - start held high across RUN/DONE → exactly one run per IDLE visit, with no extra done.
- CCG_BIST_CMP_EN with GOLDEN=16'h1B98, using the x=0 stub → pass=1 with done.
  - With GOLDEN=16'h1B99 → pass=0.

Source files
------------

// File: rtl/ccg_bist_stim_misr_if.sv
// Bus between the BIST harness and one benchmark netlist plus its regression controller.
// The master modport is the harness side; the slave modport is the environment side.
interface ccg_bist_stim_misr_if #(
    parameter int N_IN  = 5,
    parameter int N_OUT = 14,
    parameter int SIG_W = 16
);
    logic             start;
    logic [N_IN-1:0]  x;
    logic [N_OUT-1:0] f;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] signature;
    logic             pass;

    modport master (
        input  start,
        input  f,
        output x,
        output busy,
        output done,
        output signature,
        output pass
    );

    modport slave (
        output start,
        output f,
        input  x,
        input  busy,
        input  done,
        input  signature,
        input  pass
    );
endinterface

// File: rtl/ccg_bist_stim_misr.sv
// Exhaustive pattern generator and MISR compactor for GCN_AIG combinational benchmarks.
// Optional golden-signature comparator is enabled by defining CCG_BIST_CMP_EN.
module ccg_bist_stim_misr #(
    parameter int               N_IN   = 5,
    parameter int               N_OUT  = 14,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = 16'h1021,
    parameter logic [SIG_W-1:0] GOLDEN = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ccg_bist_stim_misr_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [N_IN:0]    cnt_r, cnt_s, cnt_inc_s;
    logic [SIG_W-1:0] sig_r, sig_s, sig_upd_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             last_s;
    logic             pass_r, pass_s;

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                   input logic [N_OUT-1:0] d);
        logic [SIG_W-1:0] fb;
        logic [SIG_W-1:0] ext;
        fb  = s[SIG_W-1] ? POLY : {SIG_W{1'b0}};
        ext = {SIG_W{1'b0}};
        ext[N_OUT-1:0] = d;
        return {s[SIG_W-2:0], 1'b0} ^ fb ^ ext;
    endfunction

    // The extra counter bit flags the step past the final pattern, so x never wraps.
    assign cnt_inc_s = cnt_r + {{N_IN{1'b0}}, 1'b1};
    assign last_s    = cnt_inc_s[N_IN];
    assign sig_upd_s = misr_step(sig_r, bus.f);

    // Next-state, counter, MISR and status decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        sig_s   = sig_r;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        pass_s  = pass_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = RUN;
                    cnt_s   = {(N_IN+1){1'b0}};
                    sig_s   = {SIG_W{1'b0}};
                    busy_s  = 1'b1;
                    pass_s  = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                sig_s = sig_upd_s;
                if (last_s) begin
                    state_s = DONE;
                    cnt_s   = {(N_IN+1){1'b0}};
                    done_s  = 1'b1;
`ifdef CCG_BIST_CMP_EN
                    pass_s  = (sig_upd_s == GOLDEN);
`endif
                end else begin
                    cnt_s  = cnt_inc_s;
                    busy_s = 1'b1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {(N_IN+1){1'b0}};
            end
        endcase
    end

    // State and datapath registers; reset discards any partial signature.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {(N_IN+1){1'b0}};
            sig_r   <= {SIG_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            sig_r   <= sig_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            pass_r  <= pass_s;
        end
    end

    assign bus.x         = cnt_r[N_IN-1:0];
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.signature = sig_r;
`ifdef CCG_BIST_CMP_EN
    assign bus.pass      = pass_r;
`else
    assign bus.pass      = 1'b0;
`endif

endmodule
